// File: rtl/snn_layer_mac.sv
// snn_layer_mac: fully-connected SNN layer engine. For each output neuron it
// walks the N input spikes and the matching row of the weight ROM, sums the
// signed weights of active spikes and emits the saturated sum.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           1-cycle pulse, begins a pass (ignored unless idle)
//   in_addr         spike memory address (1-cycle read latency)
//   in_spike        spike returned for the previous in_addr
//   rom_addr        weight ROM address = neuron*N + input (1-cycle latency)
//   rom_q           weight returned for the previous rom_addr
//   busy            high while a pass is in progress
//   out_valid       1-cycle pulse, out_idx/out_data valid
//   out_idx         neuron index of out_data
//   out_data        saturated neuron sum, held between pulses
//   done            1-cycle pulse with the last out_valid
//
// Build option: define SNN_MAC_RELU_EN for unsigned ReLU-clamped output;
// otherwise out_data is a signed clamp to OUT_WIDTH bits.

module snn_layer_mac #(
    parameter int NUM_INPUTS   = 784,
    parameter int NUM_OUTPUTS  = 32,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ADDR_WIDTH   = 15,
    parameter int IN_AW        = 10,
    parameter int ACC_WIDTH    = 18,
    parameter int OUT_WIDTH    = 8,
    parameter int IDX_W        = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [IN_AW-1:0]        in_addr,
    input  logic                    in_spike,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    input  logic [WEIGHT_WIDTH-1:0] rom_q,
    output logic                    busy,
    output logic                    out_valid,
    output logic [IDX_W-1:0]        out_idx,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic                    done
);

    localparam logic [IN_AW-1:0] LAST_IN = IN_AW'(NUM_INPUTS - 1);
    localparam logic [IDX_W-1:0] LAST_K  = IDX_W'(NUM_OUTPUTS - 1);

`ifdef SNN_MAC_RELU_EN
    localparam logic signed [ACC_WIDTH-1:0] UMAX =
        ACC_WIDTH'((2 ** OUT_WIDTH) - 1);
`else
    localparam logic signed [ACC_WIDTH-1:0] SMAX =
        ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SMIN =
        ACC_WIDTH'(-(2 ** (OUT_WIDTH - 1)));
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        EMIT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [IDX_W-1:0]            k;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] w_ext;
    logic [OUT_WIDTH-1:0]        sat_val;
    logic                        data_ok;
    logic                        last_in;
    logic                        last_k;
    logic                        clr;

    assign last_in = (in_addr == LAST_IN);
    assign last_k  = (k == LAST_K);
    assign busy    = (state != IDLE);
    assign w_ext   = {{(ACC_WIDTH - WEIGHT_WIDTH){rom_q[WEIGHT_WIDTH-1]}}, rom_q};

    // Accumulator restarts when a neuron begins: on the start edge and on
    // the EMIT edge that hands over to the next neuron.
    assign clr = ((state == IDLE) && start) || (state == EMIT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_in) state_nx = DRAIN;
            DRAIN:   state_nx = EMIT;
            EMIT:    state_nx = last_k ? IDLE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sat_val = acc[OUT_WIDTH-1:0];
`ifdef SNN_MAC_RELU_EN
        if (acc[ACC_WIDTH-1])  sat_val = '0;
        else if (acc > UMAX)   sat_val = '1;
`else
        if (acc > SMAX)        sat_val = SMAX[OUT_WIDTH-1:0];
        else if (acc < SMIN)   sat_val = SMIN[OUT_WIDTH-1:0];
`endif
    end

    // data_ok marks the cycle after an address cycle, when the memories
    // return the spike/weight pair for that address.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            data_ok <= 1'b0;
        end else begin
            data_ok <= (state == RUN);
            if (clr)
                acc <= '0;
            else if (data_ok && in_spike)
                acc <= acc + w_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_addr   <= '0;
            rom_addr  <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        in_addr  <= '0;
                        rom_addr <= '0;
                        k        <= '0;
                    end
                end
                RUN: begin
                    if (!last_in) begin
                        in_addr  <= in_addr + 1'b1;
                        rom_addr <= rom_addr + 1'b1;
                    end
                end
                DRAIN: begin
                end
                EMIT: begin
                    out_data  <= sat_val;
                    out_idx   <= k;
                    out_valid <= 1'b1;
                    done      <= last_k;
                    // rom_addr keeps running: k*N+N-1 -> (k+1)*N
                    if (!last_k) begin
                        k        <= k + 1'b1;
                        in_addr  <= '0;
                        rom_addr <= rom_addr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_layer_mac.sv
// tb_snn_layer_mac: directed bench for snn_layer_mac with 1-cycle-latency
// weight ROM and spike memory models.

module tb_snn_layer_mac;

    localparam int N    = 784;
    localparam int M    = 32;
    localparam int PASS = M * (N + 2);

`ifdef SNN_MAC_RELU_EN
    localparam logic [7:0] PSAT = 8'hFF;
    localparam logic [7:0] NSAT = 8'h00;
`else
    localparam logic [7:0] PSAT = 8'h7F;
    localparam logic [7:0] NSAT = 8'h80;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  in_addr;
    logic        in_spike;
    logic [14:0] rom_addr;
    logic [7:0]  rom_q;
    logic        busy;
    logic        out_valid;
    logic [4:0]  out_idx;
    logic [7:0]  out_data;
    logic        done;

    snn_layer_mac #(
        .NUM_INPUTS(N), .NUM_OUTPUTS(M), .WEIGHT_WIDTH(8),
        .ADDR_WIDTH(15), .IN_AW(10), .ACC_WIDTH(18), .OUT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_addr(in_addr), .in_spike(in_spike),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .busy(busy), .out_valid(out_valid), .out_idx(out_idx),
        .out_data(out_data), .done(done)
    );

    logic [7:0] wmem [N*M];
    logic       smem [N];
    logic [7:0] exp_d [M];

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) begin
        rom_q    <= wmem[int'(rom_addr)];
        in_spike <= smem[int'(in_addr)];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int         nv, nd, done_n, done_idx;
    int         busy0, busy_pre, busy_done, hold_d;
    int         a_in0, a_rom0, a_in5, a_rom5;
    int         got_n [64];
    int         got_i [64];
    logic [7:0] got_d [64];

    task automatic run_pass(input bit glitch);
        nv = 0; nd = 0; done_n = -1; done_idx = -1;
        busy_done = -1; busy_pre = -1; hold_d = -1;
        for (int j = 0; j < 64; j++) begin
            got_n[j] = -1; got_i[j] = -1; got_d[j] = 8'h00;
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 0; n <= PASS + 5; n++) begin
            if (out_valid && nv < 64) begin
                got_n[nv] = n;
                got_i[nv] = int'(out_idx);
                got_d[nv] = out_data;
                nv++;
            end
            if (done) begin
                nd++;
                done_n    = n;
                done_idx  = int'(out_idx);
                busy_done = int'(busy);
            end
            if (n == 0) begin
                busy0 = int'(busy);
                a_in0 = int'(in_addr);
                a_rom0 = int'(rom_addr);
            end
            if (n == N + 2 + 5) begin
                a_in5 = int'(in_addr);
                a_rom5 = int'(rom_addr);
            end
            if (n == N + 2 + 10) hold_d = int'(out_data);
            if (n == PASS - 1) busy_pre = int'(busy);
            start = glitch && (n == N + 1 || n == 5000);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic verify(input string tag);
        check({tag, "_nvalid"}, nv, M);
        for (int k = 0; k < M; k++) begin
            check($sformatf("%s_idx%0d", tag, k), got_i[k], k);
            check($sformatf("%s_t%0d", tag, k), got_n[k], (k + 1) * (N + 2));
            check($sformatf("%s_d%0d", tag, k), got_d[k], exp_d[k]);
        end
        check({tag, "_ndone"}, nd, 1);
        check({tag, "_done_t"}, done_n, PASS);
        check({tag, "_done_idx"}, done_idx, M - 1);
        check({tag, "_busy_at_done"}, busy_done, 0);
        check({tag, "_busy_pre"}, busy_pre, 1);
        check({tag, "_busy_first"}, busy0, 1);
        check({tag, "_in_addr0"}, a_in0, 0);
        check({tag, "_rom_addr0"}, a_rom0, 0);
        check({tag, "_in_addr_n1"}, a_in5, 5);
        check({tag, "_rom_addr_n1"}, a_rom5, N + 5);
        check({tag, "_hold"}, hold_d, exp_d[0]);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    task automatic load_sparse();
        for (int i = 0; i < N; i++) smem[i] = 1'b0;
        smem[0] = 1'b1; smem[5] = 1'b1; smem[N-1] = 1'b1;
        for (int j = 0; j < N * M; j++) wmem[j] = 8'($urandom_range(0, 255));
        for (int k = 0; k < M; k++) begin
            wmem[k*N]       = 8'h00;
            wmem[k*N + 5]   = 8'h00;
            wmem[k*N + N-1] = 8'h00;
            exp_d[k] = 8'h00;
        end
        wmem[2*N + 5] = 8'h23;
        exp_d[2] = 8'd35;
        wmem[4*N] = 8'd100;
        wmem[4*N + N-1] = 8'hE2;
        exp_d[4] = 8'd70;
        wmem[9*N] = 8'h80; wmem[9*N + 5] = 8'h80; wmem[9*N + N-1] = 8'hFF;
        exp_d[9] = NSAT;
        wmem[12*N] = 8'h7F; wmem[12*N + 5] = 8'h7F; wmem[12*N + N-1] = 8'h7F;
        exp_d[12] = PSAT;
    endtask

    task automatic load_dense();
        for (int i = 0; i < N; i++) smem[i] = 1'b1;
        for (int k = 0; k < M; k++) begin
            for (int i = 0; i < N; i++)
                wmem[k*N + i] = (k % 2 == 0) ? 8'h01 : 8'hFF;
            exp_d[k] = (k % 2 == 0) ? PSAT : NSAT;
        end
        for (int i = 0; i < N; i++)
            wmem[7*N + i] = (i < 400) ? 8'h01 : 8'hFF;
        exp_d[7] = 8'd16;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        load_sparse();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_idx", out_idx, 0);
        check("rst_data", out_data, 0);
        check("rst_in_addr", in_addr, 0);
        check("rst_rom_addr", rom_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // abort during neuron 10 RUN
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10 * (N + 2) + 100) @(negedge clk);
        check("abort_busy_pre", busy, 1);
        check("abort_idx_pre", out_idx, 9);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_done", done, 0);
        check("abort_idx", out_idx, 0);
        check("abort_data", out_data, 0);
        check("abort_in_addr", in_addr, 0);
        check("abort_rom_addr", rom_addr, 0);
        rst = 1'b0;
        begin
            int sv;
            sv = 0;
            repeat (N + 10) begin
                @(negedge clk);
                if (out_valid || busy) sv++;
            end
            check("abort_quiet", sv, 0);
        end

        // clean pass after abort, with start pulses while busy
        run_pass(1'b1);
        verify("sparse");

        load_dense();
        run_pass(1'b0);
        verify("dense");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
